// File: rtl/dma_status_poller.sv
// dma_status_poller
//   Polls an AXI DMA channel status register (MM2S_DMASR / S2MM_DMASR) over
//   an AXI4-Lite read channel until the DMA reports Idle, an error bit, an
//   RRESP error, or the poll budget is exhausted. Reports a one-cycle done
//   pulse with a sticky error code.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle request; chan_sel/gap_cycles/max_polls
//                         are latched with it (only in IDLE)
//   busy, done          : run in progress / one-cycle completion pulse
//   err, err_code       : sticky result (0 ok, 1 RRESP, 2 DMA error, 3 timeout)
//   last_status         : last status word read
//   poll_cnt            : completed reads in the current run (saturating)
//   M_AXI_AR*, M_AXI_R* : AXI4-Lite read address / read data channels
module dma_status_poller #(
  parameter int          GLOB_ADDR_WIDTH = 32,
  parameter int          GLOB_DATA_WIDTH = 32,
  parameter logic [31:0] DMA_BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] MM2S_SR_OFFSET  = 32'h04,
  parameter logic [31:0] S2MM_SR_OFFSET  = 32'h34,
  parameter int          POLL_GAP_WIDTH  = 8,
  parameter int          POLL_CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       chan_sel,
  input  logic [POLL_GAP_WIDTH-1:0]  gap_cycles,
  input  logic [POLL_CNT_WIDTH-1:0]  max_polls,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [GLOB_DATA_WIDTH-1:0] last_status,
  output logic [POLL_CNT_WIDTH-1:0]  poll_cnt,
  output logic [GLOB_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY
);

  localparam logic [31:0] MM2S_SUM = DMA_BASE_ADDR + MM2S_SR_OFFSET;
  localparam logic [31:0] S2MM_SUM = DMA_BASE_ADDR + S2MM_SR_OFFSET;
  localparam logic [GLOB_ADDR_WIDTH-1:0] MM2S_ADDR = GLOB_ADDR_WIDTH'(MM2S_SUM);
  localparam logic [GLOB_ADDR_WIDTH-1:0] S2MM_ADDR = GLOB_ADDR_WIDTH'(S2MM_SUM);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_GAP, S_FIN} state_t;

  state_t                    state, state_nx;
  logic [POLL_GAP_WIDTH-1:0] gap_q, gap_cnt;
  logic [POLL_CNT_WIDTH-1:0] max_q, cnt_inc;
  logic                      rd_fin;
  logic [1:0]                rd_code;

  // Outputs decoded straight from the state register: glitch-free, and
  // ARVALID/RREADY are mutually exclusive by construction.
  assign M_AXI_ARVALID = (state == S_AR);
  assign M_AXI_RREADY  = (state == S_R);
  assign busy          = (state == S_AR) || (state == S_R) || (state == S_GAP);
  assign done          = (state == S_FIN);

  assign cnt_inc = (&poll_cnt) ? poll_cnt : poll_cnt + POLL_CNT_WIDTH'(1);

  // Evaluation of the returned status word; order encodes priority, so an
  // error bit wins over Idle and RRESP wins over everything.
  always_comb begin
    rd_fin  = 1'b0;
    rd_code = 2'd0;
    if (M_AXI_RRESP != 2'b00) begin
      rd_fin  = 1'b1;
      rd_code = 2'd1;
    end else if (|M_AXI_RDATA[6:4]) begin
      rd_fin  = 1'b1;
      rd_code = 2'd2;
    end else if (M_AXI_RDATA[1]) begin
      rd_fin  = 1'b1;
      rd_code = 2'd0;
    end else if ((max_q != '0) && (cnt_inc == max_q)) begin
      rd_fin  = 1'b1;
      rd_code = 2'd3;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_AR;
      S_AR:   if (M_AXI_ARREADY) state_nx = S_R;
      S_R:    if (M_AXI_RVALID) begin
                if (rd_fin)            state_nx = S_FIN;
                else if (gap_q == '0)  state_nx = S_AR;
                else                   state_nx = S_GAP;
              end
      // <= 1 rather than == 1 so a zero count can never wedge the FSM
      S_GAP:  if (gap_cnt <= POLL_GAP_WIDTH'(1)) state_nx = S_AR;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      M_AXI_ARADDR <= '0;
      gap_q        <= '0;
      max_q        <= '0;
      gap_cnt      <= '0;
      poll_cnt     <= '0;
      last_status  <= '0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: if (start) begin
          // Address is fixed for the whole run, so it is trivially stable
          // while ARVALID is high.
          M_AXI_ARADDR <= chan_sel ? S2MM_ADDR : MM2S_ADDR;
          gap_q        <= gap_cycles;
          max_q        <= max_polls;
          poll_cnt     <= '0;
          err          <= 1'b0;
          err_code     <= 2'd0;
        end
        S_R: if (M_AXI_RVALID) begin
          last_status <= M_AXI_RDATA;
          poll_cnt    <= cnt_inc;
          if (rd_fin) begin
            // Result lands on the FIN transition so err is valid with done.
            err_code <= rd_code;
            err      <= (rd_code != 2'd0);
          end else begin
            gap_cnt  <= gap_q;
          end
        end
        S_GAP: gap_cnt <= gap_cnt - POLL_GAP_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dma_status_poller.md
Name: dma_status_poller

Overview:
- Sequencer-side read engine that drives the AXI4-Lite master read channel toward the AXI DMA.
- On a start pulse it polls the selected DMA channel status register (MM2S_DMASR or S2MM_DMASR) until the DMA reports Idle, an error, or the poll budget runs out.
- It reports the result to the sequencer FSM as a one-cycle done pulse plus a sticky error code.

Parameters:
- GLOB_ADDR_WIDTH, 32, AXI address width.
- GLOB_DATA_WIDTH, 32, AXI data width.
- DMA_BASE_ADDR, 32'h0000_0000, DMA register-space base address.
- MM2S_SR_OFFSET, 32'h04, MM2S status register offset.
- S2MM_SR_OFFSET, 32'h34, S2MM status register offset.
- POLL_GAP_WIDTH, 8, width of the inter-poll gap counter.
- POLL_CNT_WIDTH, 16, width of the poll counter and poll limit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin polling
- chan_sel  in  1  0 = MM2S, 1 = S2MM; sampled with start
- gap_cycles  in  POLL_GAP_WIDTH  idle cycles between polls; sampled with start
- max_polls  in  POLL_CNT_WIDTH  poll limit; 0 = unlimited; sampled with start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, valid from done
- err_code  out  2  0 = ok, 1 = RRESP error, 2 = DMA error bits, 3 = timeout
- last_status  out  GLOB_DATA_WIDTH  last captured status word
- poll_cnt  out  POLL_CNT_WIDTH  completed reads in the current run
- M_AXI_ARADDR  out  GLOB_ADDR_WIDTH  read address
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  GLOB_DATA_WIDTH
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- One clock, clk. Reset is synchronous and active-high. On reset all outputs are 0 and the state is IDLE.
- States: IDLE, AR, R, GAP, FIN.
- IDLE:
  - start=1 latches chan_sel, gap_cycles and max_polls, clears poll_cnt, err and err_code, and moves to AR.
  - start in any other state is ignored.
- AR:
  - ARVALID=1 (registered); ARADDR = DMA_BASE_ADDR + selected offset, held stable while ARVALID.
  - On ARVALID && ARREADY, go to R. ARVALID drops in the following cycle.
- R:
  - RREADY=1 (registered).
  - On RVALID && RREADY: capture RDATA into last_status, poll_cnt += 1 (saturating), then evaluate in the same cycle.
  - Evaluation priority:
    a) RRESP != 0: err_code=1, go to FIN.
    b) RDATA bits 4, 5 or 6 set (IntErr/SlvErr/DecErr): err_code=2, go to FIN.
    c) RDATA bit 1 set (Idle): err_code=0, go to FIN.
    d) max_polls != 0 and new poll_cnt == max_polls: err_code=3, go to FIN.
    e) Otherwise go to GAP, or directly to AR if gap_cycles == 0.
- GAP: counter loads gap_cycles and decrements once per cycle; at 1, go to AR. Exactly gap_cycles cycles elapse with ARVALID=0.
- FIN: done=1 for exactly one cycle; err = (err_code != 0); next state IDLE. err, err_code and last_status hold until the next accepted start.
- busy is 1 in AR, R and GAP, and 0 in IDLE and FIN.
- Minimum latency, with ARREADY and RVALID tied high and the first read returning Idle:
  - start at cycle 0
  - ARVALID at cycle 1
  - RREADY at cycle 2, R handshake at cycle 2
  - done at cycle 3
- At most one outstanding read. ARVALID and RREADY are never high in the same cycle.
- Reset mid-transaction returns to IDLE the next edge and drops ARVALID/RREADY. This is permitted because the DMA shares the same reset.
- A status word with both an error bit and the Idle bit set reports err_code=2.

Test Plan:
- Zero-wait slave, chan_sel=0, RDATA=32'h2 → ARADDR = base+0x04, done at cycle 3 after start, err=0, poll_cnt=1.
- chan_sel=1, gap_cycles=3, slave returns 32'h0 twice then 32'h2 → ARADDR = base+0x34; exactly 3 idle cycles between reads; done with poll_cnt=3, err_code=0.
- ARREADY held low 5 cycles, RVALID delayed 4 → ARVALID and ARADDR stable throughout; no second AR issued; correct completion.
- RRESP=2'b10 with RDATA=32'h2 → err=1, err_code=1, done pulse.
- RDATA=32'h22 (SlvErr+Idle) → err_code=2.
- max_polls=4, slave always returns 32'h0 → 4 reads, err_code=3. Repeat with max_polls=0 and 20 reads, assert reset mid-R → ARVALID/RREADY=0, busy=0 after the reset edge; a start during busy is ignored.
